// File: rtl/tdm_demux_rx.sv
// TDM sample-link receiver: steers one sample per valid cycle into a channel
// slot and publishes each complete frame as a double-buffered parallel word.
module tdm_demux_rx #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CW    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic [CW-1:0]            ch_idx,
    output logic                     frame_err
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    state_e                    state_q, state_d;
    logic [CW-1:0]             ch_idx_q, ch_idx_d;
    logic [DATA_W-1:0]         shadow_q [NUM_CH];
    logic [DATA_W-1:0]         shadow_d [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]  out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (in_sof) begin
                        shadow_d[0] = in_data;
                        ch_idx_d    = CW'(1);
                        state_d     = COLLECT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (in_sof) begin
                        // Early sof restarts the frame with this sample as ch0.
                        frame_err_d = 1'b1;
                        shadow_d[0] = in_data;
                        ch_idx_d    = CW'(1);
                    end else begin
                        shadow_d[ch_idx_q] = in_data;
                        if (ch_idx_q == LAST_CH) begin
                            // Publish from shadow_d so the closing sample lands on the same edge.
                            for (int unsigned k = 0; k < NUM_CH; k++) begin
                                out_data_d[k*DATA_W +: DATA_W] = shadow_d[k];
                            end
                            out_valid_d = 1'b1;
                            ch_idx_d    = '0;
                            state_d     = IDLE;
                        end else begin
                            ch_idx_d = ch_idx_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    ch_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_idx_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            shadow_q    <= shadow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ch_idx    = ch_idx_q;
    assign frame_err = frame_err_q;

endmodule
